// File: rtl/rcv_fifo_if.sv
// ---------------------------------------------------------------------------
// rcv_fifo_if
// Bus bundle between the serial controller register side and the rcv_fifo
// receiver.
//   bit_len      bit period minus one, in clk cycles
//   parity_mode  00/01 none, 10 even, 11 odd
//   serial_in    asynchronous serial line, idle high
//   rd           pop the FIFO head
//   clr_err      clear the sticky overrun / break_det flags
//   rdy          FIFO non-empty
//   parallel_out head data, LSB = first received bit
//   frame_err    head entry stop bit was 0
//   parity_err   head entry parity mismatch
//   overrun      sticky: a frame was dropped on a full FIFO
//   break_det    sticky: a break frame was received
// master = controller side, slave = receiver.
// ---------------------------------------------------------------------------
interface rcv_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [15:0]          bit_len;
    logic [1:0]           parity_mode;
    logic                 serial_in;
    logic                 rd;
    logic                 clr_err;
    logic                 rdy;
    logic [DATA_BITS-1:0] parallel_out;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 break_det;

    modport master (
        output bit_len, parity_mode, serial_in, rd, clr_err,
        input  rdy, parallel_out, frame_err, parity_err, overrun, break_det
    );

    modport slave (
        input  bit_len, parity_mode, serial_in, rd, clr_err,
        output rdy, parallel_out, frame_err, parity_err, overrun, break_det
    );
endinterface

// File: rtl/rcv_fifo.sv
// ---------------------------------------------------------------------------
// rcv_fifo
// Serial line receiver: 5..9 data bits, optional even/odd parity, programmable
// bit period. Received frames are stored with framing/parity error flags in
// a show-ahead FIFO of 2^FIFO_LOG2 entries. Rejects false start bits, flags
// line breaks and FIFO overruns.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  rcv_fifo_if.slave (line input, config, FIFO head and status)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | line idle, waiting for serial_s low
// S_START   | waiting for mid-start-bit tick to confirm the start
// S_DATA    | sampling DATA_BITS data bits, LSB first
// S_PAR     | sampling the parity bit
// S_STOP    | sampling the stop bit, pushing the frame
// S_WAIT_HI | frame error seen, waiting for the line to return high
// ---------------------------------------------------------------------------
module rcv_fifo #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    rcv_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int EW    = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic                 serial_s;
    logic [15:0]          count_q, count_d;
    logic [15:0]          bit_len_q, bit_len_d;
    logic [1:0]           pmode_q, pmode_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tick;

    logic                 push;
    logic                 frame_err_w;
    logic                 parity_err_w;
    logic                 brk_set;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem_q [DEPTH];
    logic [FIFO_LOG2:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 empty, full, pop, push_ok;
    logic                 overrun_q, overrun_d;
    logic                 brk_q, brk_d;
    logic [EW-1:0]        head;

    // Synchroniser resets to the idle level so reset release cannot look
    // like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign serial_s = sync2_q;
    assign tick     = (count_q == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bit_len_q <= '0;
            pmode_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_len_q <= bit_len_d;
            pmode_q   <= pmode_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        bit_len_d    = bit_len_q;
        pmode_d      = pmode_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        push         = 1'b0;
        frame_err_w  = 1'b0;
        parity_err_w = 1'b0;
        brk_set      = 1'b0;

        if (state_q != S_IDLE && state_q != S_WAIT_HI) begin
            count_d = tick ? bit_len_q : count_q - 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!serial_s) begin
                    bit_len_d = bus.bit_len;
                    pmode_d   = bus.parity_mode;
                    count_d   = bus.bit_len >> 1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (serial_s) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {serial_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d = pmode_q[1] ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (tick) begin
                    par_d   = serial_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    frame_err_w  = ~serial_s;
                    // pmode_q[0] inverts the sense for odd parity
                    parity_err_w = pmode_q[1] & ((^shift_q) ^ par_q ^ pmode_q[0]);
                    push         = 1'b1;
                    brk_set      = frame_err_w && (shift_q == '0) &&
                                   (!pmode_q[1] || !par_q);
                    state_d      = frame_err_w ? S_WAIT_HI : S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (serial_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push_entry = {parity_err_w, frame_err_w, shift_q};

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[FIFO_LOG2] != rptr_q[FIFO_LOG2]) &&
                     (wptr_q[FIFO_LOG2-1:0] == rptr_q[FIFO_LOG2-1:0]);
    assign pop     = bus.rd && !empty;
    // Pop is taken first, so a push into a full FIFO that is popped in the
    // same cycle lands in the slot just vacated by the head.
    assign push_ok = push && (!full || pop);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        overrun_d = overrun_q;
        brk_d     = brk_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (bus.clr_err) begin
            overrun_d = 1'b0;
            brk_d     = 1'b0;
        end
        if (push && !push_ok) begin
            overrun_d = 1'b1;
        end
        if (brk_set) begin
            brk_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
            brk_q     <= brk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wptr_q[FIFO_LOG2-1:0]] <= push_entry;
        end
    end

    assign head             = mem_q[rptr_q[FIFO_LOG2-1:0]];
    assign bus.rdy          = !empty;
    assign bus.parallel_out = empty ? '0 : head[DATA_BITS-1:0];
    assign bus.frame_err    = !empty && head[DATA_BITS];
    assign bus.parity_err   = !empty && head[DATA_BITS+1];
    assign bus.overrun      = overrun_q;
    assign bus.break_det    = brk_q;
endmodule

// File: tb/tb_rcv_fifo.sv
module tb_rcv_fifo;
    localparam int DATA_BITS = 8;
    localparam int FIFO_LOG2 = 2;
    localparam int DEPTH     = 1 << FIFO_LOG2;
    localparam int NV        = 10;

    logic clk = 1'b0;
    logic rst;

    rcv_fifo_if #(.DATA_BITS(DATA_BITS)) bus ();

    rcv_fifo #(.DATA_BITS(DATA_BITS), .FIFO_LOG2(FIFO_LOG2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] pmode;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
        logic       exp_brk;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ent_t;

    vec_t vecs [NV];
    ent_t model_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        bus.clr_err = 1'b1;
        cyc();
        bus.clr_err = 1'b0;
    endtask

    // Drives one frame plus a 4-cycle high gap. rise_at is the number of edges
    // after the call at which rdy went 0->1 (-1 if never). rd_at pulses rd for
    // one cycle; abort_at asserts rst instead of finishing the frame.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] pmode,
                              input logic par_bit, input logic stop, input int l,
                              input int rd_at, input int abort_at, output int rise_at);
        logic line [$];
        int   nline;
        int   total;
        logic prev_rdy;
        bus.bit_len     = 16'(l);
        bus.parity_mode = pmode;
        line.push_back(1'b0);
        for (int i = 0; i < DATA_BITS; i++) line.push_back(data[i]);
        if (pmode[1]) line.push_back(par_bit);
        line.push_back(stop);
        nline    = line.size() * (l + 1);
        total    = nline + 4;
        rise_at  = -1;
        prev_rdy = bus.rdy;
        for (int c = 0; c < total; c++) begin
            bus.serial_in = (c < nline) ? line[c / (l + 1)] : 1'b1;
            bus.rd        = (c == rd_at);
            if (c == abort_at) begin
                rst           = 1'b1;
                bus.serial_in = 1'b1;
                bus.rd        = 1'b0;
                cyc();
                rst = 1'b0;
                return;
            end
            cyc();
            if (!prev_rdy && bus.rdy && rise_at < 0) rise_at = c + 1;
            prev_rdy = bus.rdy;
        end
        bus.rd = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        check({tag, " rdy"}, bus.rdy, 1);
        check({tag, " data"}, bus.parallel_out, d);
        check({tag, " frame_err"}, bus.frame_err, fe);
        check({tag, " parity_err"}, bus.parity_err, pe);
        bus.rd = 1'b1;
        cyc();
        bus.rd = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rdy"}, bus.rdy, 0);
        check({tag, " parallel_out"}, bus.parallel_out, 0);
        check({tag, " frame_err"}, bus.frame_err, 0);
        check({tag, " parity_err"}, bus.parity_err, 0);
        check({tag, " overrun"}, bus.overrun, 0);
        check({tag, " break_det"}, bus.break_det, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rise;
        int n;
        int exp_rise;
        logic m_ovr;
        logic m_brk;

        //            data   pm    par   stop  exp_d  fe    pe    brk
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 2'b10, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 2'b10, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h07, 2'b11, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 2'b11, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 2'b01, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'hFF, 2'b01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'h81, 2'b11, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};

        rst             = 1'b1;
        bus.bit_len     = 16'd9;
        bus.parity_mode = 2'b00;
        bus.serial_in   = 1'b1;
        bus.rd          = 1'b0;
        bus.clr_err     = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // rd on an empty FIFO must be ignored
        bus.rd = 1'b1;
        repeat (3) cyc();
        bus.rd = 1'b0;
        check("rd when empty rdy", bus.rdy, 0);

        // table of single frames, bit_len = 9
        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].data, vecs[i].pmode, vecs[i].par, vecs[i].stop, 9, -1, -1, rise);
            n        = 2 + DATA_BITS + (vecs[i].pmode[1] ? 1 : 0);
            exp_rise = 4 + (9 >> 1) + (n - 1) * 10;
            check($sformatf("vec%0d rdy rise cycle", i), rise, exp_rise);
            check($sformatf("vec%0d break_det", i), bus.break_det, vecs[i].exp_brk);
            pop_check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe);
            check($sformatf("vec%0d rdy after rd", i), bus.rdy, 0);
            clr_pulse();
        end

        // 3-cycle low glitch: false start, nothing pushed
        bus.serial_in = 1'b0;
        repeat (3) cyc();
        bus.serial_in = 1'b1;
        repeat (30) cyc();
        check("glitch rdy", bus.rdy, 0);

        // line break: 30 bit periods low gives exactly one entry
        bus.bit_len     = 16'd9;
        bus.parity_mode = 2'b00;
        bus.serial_in   = 1'b0;
        repeat (300) cyc();
        bus.serial_in = 1'b1;
        repeat (20) cyc();
        check("break break_det", bus.break_det, 1);
        pop_check("break entry", 8'h00, 1'b1, 1'b0);
        check("break single entry", bus.rdy, 0);
        check("break_det sticky", bus.break_det, 1);
        clr_pulse();
        check("break_det cleared", bus.break_det, 0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 9, -1, -1, rise);
        pop_check("after break", 8'h3C, 1'b0, 1'b0);
        check("after break empty", bus.rdy, 0);

        // overrun: 5 frames into a 4-deep FIFO
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 2'b00, 1'b0, 1'b1, 9, -1, -1, rise);
        check("overrun set", bus.overrun, 1);
        for (int i = 0; i < 4; i++) pop_check($sformatf("ovr%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0);
        check("ovr drained", bus.rdy, 0);
        clr_pulse();
        check("overrun cleared", bus.overrun, 0);

        // rd in the same cycle as a push into a full FIFO
        for (int i = 0; i < 4; i++) send_frame(8'h20 + 8'(i), 2'b00, 1'b0, 1'b1, 9, -1, -1, rise);
        check("full no overrun", bus.overrun, 0);
        check("full head", bus.parallel_out, 8'h20);
        send_frame(8'h24, 2'b00, 1'b0, 1'b1, 9, 3 + (9 >> 1) + 9 * 10, -1, rise);
        check("pop+push no overrun", bus.overrun, 0);
        for (int i = 1; i < 5; i++) pop_check($sformatf("popush%0d", i), 8'h20 + 8'(i), 1'b0, 1'b0);
        check("popush drained", bus.rdy, 0);

        // reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i), 2'b00, 1'b0, 1'b1, 9, -1, -1, rise);
        check("pre-reset overrun", bus.overrun, 1);
        send_frame(8'h55, 2'b00, 1'b0, 1'b1, 9, -1, 43, rise);
        check_all_zero("mid-frame reset");
        cyc();
        send_frame(8'h81, 2'b00, 1'b0, 1'b1, 9, -1, -1, rise);
        pop_check("post reset", 8'h81, 1'b0, 1'b0);
        check("post reset empty", bus.rdy, 0);

        // randomized frames against a queue model, reads interleaved
        m_ovr = 1'b0;
        m_brk = 1'b0;
        model_q.delete();
        for (int f = 0; f < 20; f++) begin
            logic [7:0] d;
            logic [1:0] pm;
            logic       pb;
            logic       sb;
            int         l;
            int         ones;
            int         k;
            ent_t       e;
            d  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            pm = 2'($urandom);
            l  = $urandom_range(4, 14);
            ones = $countones(d);
            pb = (pm == 2'b11) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            if (!pm[1]) pb = 1'b0;
            sb = ($urandom_range(0, 4) != 0);
            send_frame(d, pm, pb, sb, l, -1, -1, rise);

            e.d  = d;
            e.fe = !sb;
            if (!pm[1])              e.pe = 1'b0;
            else if (pm == 2'b10)    e.pe = ((ones + pb) % 2) != 0;
            else                     e.pe = ((ones + pb) % 2) == 0;
            if (model_q.size() < DEPTH) model_q.push_back(e);
            else                        m_ovr = 1'b1;
            if (!sb && d == 8'h00 && (!pm[1] || !pb)) m_brk = 1'b1;

            k = $urandom_range(0, 2);
            for (int j = 0; j < k; j++) begin
                if (model_q.size() > 0) begin
                    e = model_q.pop_front();
                    pop_check($sformatf("rnd f%0d", f), e.d, e.fe, e.pe);
                end
            end
            check($sformatf("rnd f%0d rdy", f), bus.rdy, model_q.size() != 0);
            check($sformatf("rnd f%0d overrun", f), bus.overrun, m_ovr);
            check($sformatf("rnd f%0d break_det", f), bus.break_det, m_brk);
        end
        while (model_q.size() > 0) begin
            ent_t e;
            e = model_q.pop_front();
            pop_check("rnd drain", e.d, e.fe, e.pe);
        end
        check("rnd final empty", bus.rdy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rcv_fifo.md
# rcv_fifo

Parametrised serial line receiver for the UART path, the next generation of the existing 8N1 receiver. It deserialises asynchronous frames with 5–9 data bits, optional even/odd parity and a programmable bit period. Each frame is stored with per-frame framing and parity error flags in a show-ahead receive FIFO. It also rejects false start bits and detects line breaks and overruns. It sits between the pad synchroniser input and the bus-side serial controller register interface.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9.
- FIFO_LOG2, 2, FIFO depth = 2^FIFO_LOG2 entries, legal 1..6.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- bit_len  in  16  bit period minus one, in clk cycles. Sampled at start detection.
- parity_mode  in  2  00 or 01 none, 10 even, 11 odd. Sampled at start detection.
- serial_in  in  1  asynchronous line, idle high.
- rd  in  1  pop FIFO head. Ignored when rdy=0.
- clr_err  in  1  clear the sticky overrun and break_det flags.
- rdy  out  1  FIFO non-empty.
- parallel_out  out  DATA_BITS  head data, LSB = first received bit. Forced 0 when rdy=0.
- frame_err  out  1  head entry stop bit was 0. Forced 0 when rdy=0.
- parity_err  out  1  head entry parity mismatch. Forced 0 when rdy=0.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- break_det  out  1  sticky: a break frame was received.

## Operation
- serial_in passes through a 2-FF synchroniser, giving serial_s. All decisions use serial_s.
- Down-counter `count`, 16 bit. A "tick" is a cycle with count==0. On a tick the receiver samples serial_s and reloads count from the latched bit_len. Otherwise count decrements.
- States and transitions:
  - IDLE: when serial_s==0, latch bit_len and parity_mode, set count = bit_len>>1, go to START.
  - START: on a tick, if serial_s==1 the start is false; go to IDLE and push nothing. Otherwise clear the bit counter and go to DATA.
  - DATA: on each tick, shift serial_s in at the MSB of a DATA_BITS shift register (LSB-first line order). After DATA_BITS ticks go to PAR if parity is enabled, else STOP.
  - PAR: on a tick, store the parity bit and go to STOP.
  - STOP: on a tick, frame_err = ~serial_s.
    - parity_err = (XOR of data bits ^ parity bit) != 0 for even parity. For odd parity, the complement. Always 0 with no parity.
    - Push {parity_err, frame_err, data} to the FIFO.
    - break = frame_err && data==0 && (no parity, or parity bit==0). A break sets break_det.
    - If frame_err, go to WAIT_HI, else go to IDLE.
  - WAIT_HI: stay until serial_s==1, then go to IDLE. This prevents a held-low line from retriggering.
- FIFO behaviour:
  - Show-ahead: the head is valid on the outputs whenever rdy=1.
  - Push when full drops the frame and sets overrun. FIFO contents are unchanged.
  - rd together with a push in the same cycle: the pop happens first. A push to a full FIFO in that cycle is therefore accepted, and overrun is not set.
  - Read and write pointers are FIFO_LOG2+1 bits and wrap naturally. Full and empty are decided from the MSB difference.
- clr_err clears overrun and break_det. If clr_err coincides with a new set event, the set wins.
- rst mid-frame: the state returns to IDLE, the FIFO empties, and the sticky flags clear. The partial frame is discarded.

## Timing
- Reset values: rdy=0, parallel_out=0, frame_err=0, parity_err=0, overrun=0, break_det=0.
- Bit period is bit_len+1 cycles. The first tick is bit_len/2+1 cycles after the IDLE cycle that sees serial_s==0 (mid-start-bit).
- Synchroniser latency is 2 cycles from a serial_in edge to serial_s.
- Push occurs in the STOP tick cycle. rdy and the head outputs update on the following cycle.
- rd is registered. The head advances, or rdy falls, on the cycle after rd.
- A new start bit is accepted on the cycle after returning to IDLE, so back-to-back frames with exactly one stop bit are received.
- bit_len < 2 is unsupported.

## Test plan
- Basic frame: DATA_BITS=8, bit_len=9, no parity, send 0xA5 8N1. Required: rdy rises 1 cycle after the stop tick, parallel_out=0xA5, frame_err=0 and parity_err=0. After rd, rdy=0.
- Parity: parity_mode=10, send 0x07 with parity bit 1 → parity_err=0. Send 0x07 with parity bit 0 → parity_err=1. parity_mode=11, send 0x07 with parity bit 0 → parity_err=0.
- False start and framing: a 3-cycle low glitch produces no push and returns to IDLE. A frame with stop=0 gives frame_err=1, and the next frame is not started until the line has returned high.
- Break: hold serial_in low for 30 bit periods. Required: exactly one entry with data=0x00 and frame_err=1, break_det=1 until clr_err, then one clean frame 0x3C is received.
- Overrun/wrap: FIFO_LOG2=2, send 5 frames with no rd. Required: 4 entries are kept in order, the 5th is dropped and overrun=1. Then interleave rd and receive 20 frames; all are delivered in order, including a rd coinciding with a push while full.
- Reset mid-frame: assert rst during DATA of 0x55. Required: all outputs are at reset values, and the next frame 0x81 is received correctly.
